// File: rtl/arts_pkg.sv
// rtl/arts_pkg.sv - shared constants and helpers for the ARTS approximate multiplier
package arts_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) begin
            r = i + 1;
         end
      end
      return (r < 1) ? 1 : r;
   endfunction

   // Geometry of the default build (N = 16, W = 2)
   localparam int ARTS_N = 16;
   localparam int ARTS_W = 2;
   localparam int NSEG   = ARTS_N / ARTS_W;
   localparam int KW     = clog2(NSEG);
   localparam int SW     = clog2(2 * NSEG - 1);

   localparam logic FILL_ONES = 1'b0;
   localparam logic FILL_ZERO = 1'b1;

endpackage

// File: rtl/arts_lsd.sv
// rtl/arts_lsd.sv - leading non-zero segment detector for one operand
module arts_lsd
   import arts_pkg::*;
#(
   parameter  int N     = 16,
   parameter  int W     = 2,
   localparam int SEGS  = N / W,
   localparam int KBITS = clog2(SEGS)
) (
   input  logic [N-1:0]     x,
   output logic [KBITS-1:0] k,
   output logic [W-1:0]     xh,
   output logic [W-1:0]     xl
);

   // Ascending scan: the last non-zero segment seen wins, i.e. the highest one.
   always_comb begin
      k  = '0;
      xh = x[W-1:0];
      xl = '0;
      for (int i = 1; i < SEGS; i++) begin
         if (x[i*W +: W] != '0) begin
            k  = KBITS'(i);
            xh = x[i*W +: W];
            xl = x[(i-1)*W +: W];
         end
      end
   end

endmodule

// File: rtl/arts_mult_pipe.sv
// rtl/arts_mult_pipe.sv - 3-stage pipelined ARTS leading-segment approximate multiplier
module arts_mult_pipe
   import arts_pkg::*;
#(
   parameter  int N     = 16,
   parameter  int W     = 2,
   localparam int SEGS  = N / W,
   localparam int KBITS = clog2(SEGS),
   localparam int SBITS = clog2(2 * SEGS - 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   A,
   input  logic [N-1:0]   B,
   input  logic           mode,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] OUT
);

   logic stall;
   logic adv;

   assign stall    = out_valid & ~out_ready;
   assign adv      = ~stall;
   assign in_ready = adv;

   logic [KBITS-1:0] ka_c, kb_c;
   logic [W-1:0]     ah_c, al_c, bh_c, bl_c;

   arts_lsd #(.N(N), .W(W)) u_lsd_a (
      .x  (A),
      .k  (ka_c),
      .xh (ah_c),
      .xl (al_c)
   );

   arts_lsd #(.N(N), .W(W)) u_lsd_b (
      .x  (B),
      .k  (kb_c),
      .xh (bh_c),
      .xl (bl_c)
   );

   logic             v1;
   logic [KBITS-1:0] ka1, kb1;
   logic [W-1:0]     ah1, al1, bh1, bl1;
   logic             md1;

   logic             v2;
   logic [2*W-1:0]   m2;
   logic             z2;
   logic [SBITS-1:0] s2;
   logic             md2;

   logic             c_nxt;
   logic [2*W-1:0]   m_nxt;
   logic             z_nxt;
   logic [SBITS-1:0] s_nxt;

   // Core: product of leading segments plus a rounding term when the next
   // segment of either operand carries its MSB against the other's leading MSB.
   always_comb begin
      c_nxt    = (ah1[W-1] & bl1[W-1]) | (al1[W-1] & bh1[W-1]);
      m_nxt    = ((2*W)'(ah1) * (2*W)'(bh1)) + ((2*W)'(c_nxt) << (W - 1));
      m_nxt[0] = m_nxt[0] | c_nxt;
      z_nxt    = (ah1 != '0) & (bh1 != '0);
      s_nxt    = SBITS'(ka1) + SBITS'(kb1);
   end

   logic [2*N-1:0] asm_nxt;
   int             sh;

   always_comb begin
      sh      = W * int'(s2);
      asm_nxt = '0;
      if (z2) begin
         asm_nxt = (2*N)'(m2) << sh;
         if (md2 == FILL_ONES) begin
            asm_nxt = asm_nxt | ~({(2*N){1'b1}} << sh);
         end
      end
   end

   // Whole pipe advances together; data registers load only behind a valid bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1        <= 1'b0;
         ka1       <= '0;
         kb1       <= '0;
         ah1       <= '0;
         al1       <= '0;
         bh1       <= '0;
         bl1       <= '0;
         md1       <= 1'b0;
         v2        <= 1'b0;
         m2        <= '0;
         z2        <= 1'b0;
         s2        <= '0;
         md2       <= 1'b0;
         out_valid <= 1'b0;
         OUT       <= '0;
      end else if (adv) begin
         v1 <= in_valid;
         if (in_valid) begin
            ka1 <= ka_c;
            kb1 <= kb_c;
            ah1 <= ah_c;
            al1 <= al_c;
            bh1 <= bh_c;
            bl1 <= bl_c;
            md1 <= mode;
         end
         v2 <= v1;
         if (v1) begin
            m2  <= m_nxt;
            z2  <= z_nxt;
            s2  <= s_nxt;
            md2 <= md1;
         end
         out_valid <= v2;
         if (v2) begin
            OUT <= asm_nxt;
         end
      end
   end

endmodule

// File: tb/tb_arts_mult_pipe.sv
// tb/tb_arts_mult_pipe.sv - self-checking bench for arts_mult_pipe
module tb_arts_mult_pipe;
   import arts_pkg::*;

   localparam int N  = 16;
   localparam int W  = 2;
   localparam int NS = N / W;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   A;
   logic [N-1:0]   B;
   logic           mode;
   logic           out_valid;
   logic           out_ready;
   logic [2*N-1:0] OUT;

   int errors = 0;
   int checks = 0;

   logic [63:0]    exp_q[$];
   logic [2*N-1:0] held;
   bit             was_stall = 0;
   int             got = 0;

   always #5 clk = ~clk;

   arts_mult_pipe #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .OUT       (OUT)
   );

   function automatic int seg(input int x, input int i);
      return (x >> (W * i)) & ((1 << W) - 1);
   endfunction

   function automatic logic [63:0] model(input int a, input int b, input bit md);
      int ka, kb, ah, al, bh, bl, c, m, s;
      int half;
      logic [63:0] p;
      half = 1 << (W - 1);
      ka = 0;
      kb = 0;
      for (int i = 1; i < NS; i++) begin
         if (seg(a, i) != 0) ka = i;
         if (seg(b, i) != 0) kb = i;
      end
      ah = seg(a, ka);
      al = (ka > 0) ? seg(a, ka - 1) : 0;
      bh = seg(b, kb);
      bl = (kb > 0) ? seg(b, kb - 1) : 0;
      if (ah == 0 || bh == 0) return 64'd0;
      c = ((ah >= half && bl >= half) || (al >= half && bh >= half)) ? 1 : 0;
      m = ah * bh + c * half;
      if (c != 0) m = m | 1;
      s = ka + kb;
      p = 64'(m) << (W * s);
      if (md == FILL_ONES) p = p + ((64'd1 << (W * s)) - 64'd1);
      return p;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick(output bit inf);
      bit outf;
      #3;
      chk("in_ready_vs_stall", in_ready, !(out_valid && !out_ready));
      if (was_stall) begin
         chk("stall_hold_valid", out_valid, 1);
         chk("stall_hold_out", OUT, held);
      end
      inf       = in_valid && in_ready;
      outf      = out_valid && out_ready;
      was_stall = out_valid && !out_ready;
      held      = OUT;
      if (outf) begin
         chk("no_extra_result", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            chk("stream_out", OUT, exp_q.pop_front());
            got++;
         end
      end
      if (inf) exp_q.push_back(model(A, B, mode));
      @(posedge clk);
      #1;
   endtask

   task automatic new_pair();
      A    = N'($urandom) >> $urandom_range(0, N);
      B    = N'($urandom) >> $urandom_range(0, N);
      mode = 1'($urandom);
   endtask

   task automatic run_stream(input int n, input bit rnd, input int st_lo, input int st_hi);
      int idx;
      int cyc;
      bit inf;
      idx       = 0;
      cyc       = 0;
      got       = 0;
      was_stall = 0;
      exp_q.delete();
      new_pair();
      while (got < n && cyc < 400) begin
         in_valid  = (idx < n);
         out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= st_lo && cyc <= st_hi);
         tick(inf);
         if (inf) begin
            idx++;
            new_pair();
         end
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stream_count", got, n);
      chk("stream_drained", exp_q.size(), 0);
   endtask

   task automatic single(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit md, input logic [2*N-1:0] expv);
      A         = a;
      B         = b;
      mode      = md;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #2;
      chk({tag, "_in_ready"}, in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk({tag, "_lat1"}, out_valid, 0);
      @(posedge clk);
      #1;
      chk({tag, "_lat2"}, out_valid, 0);
      @(posedge clk);
      #1;
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_out"}, OUT, expv);
      @(posedge clk);
      #1;
      chk({tag, "_drain"}, out_valid, 0);
   endtask

   initial begin
      logic [N-1:0] ra, rb;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      A         = '0;
      B         = '0;
      mode      = 1'b0;
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out", OUT, 0);
      chk("reset_in_ready", in_ready, 1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      single("small_3x3", 16'h0003, 16'h0003, 1'b0, 32'h0000_0009);
      single("msb_fill1", 16'h8000, 16'h8000, 1'b0, 32'h4FFF_FFFF);
      single("msb_fill0", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
      single("cross_c1",  16'hE000, 16'hB000, 1'b0, 32'h9FFF_FFFF);
      single("cross_mdl", 16'hE000, 16'h4000, 1'b0, model(32'hE000, 32'h4000, 1'b0));
      single("c000_sq",   16'hC000, 16'hC000, 1'b0, 32'h9FFF_FFFF);
      single("zero_a_m0", 16'h0000, 16'h1234, 1'b0, 32'h0000_0000);
      single("zero_a_m1", 16'h0000, 16'h1234, 1'b1, 32'h0000_0000);
      single("zero_b_m0", 16'h4321, 16'h0000, 1'b0, 32'h0000_0000);
      for (int i = 0; i < 4; i++) begin
         ra = N'($urandom_range(0, 3));
         rb = N'($urandom_range(0, 3));
         single("exact_small", ra, rb, 1'($urandom), 32'(ra * rb));
      end

      run_stream(8, 1'b0, 5, 8);
      run_stream(40, 1'b1, 0, -1);

      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         A    = N'($urandom) | 16'h0001;
         B    = N'($urandom) | 16'h0001;
         mode = 1'b0;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("pre_rst_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_out", OUT, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("post_rst_no_stale", out_valid, 0);
         @(posedge clk);
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
